// File: rtl/ysyx_23060077_idu_queue.sv
// Registered decode stage between IFU and EXU: decodes RV32I(+M) at enqueue and buffers bundles in a FIFO.
// Define YSYX_23060077_IDU_MEXT_EN to decode the M extension (funct7=0000001 under OP).

`ifndef YSYX_23060077_ALU_ADD
`define YSYX_23060077_ALU_ADD  0
`define YSYX_23060077_ALU_SUB  1
`define YSYX_23060077_ALU_SLT  2
`define YSYX_23060077_ALU_SLTU 3
`define YSYX_23060077_ALU_XOR  4
`define YSYX_23060077_ALU_OR   5
`define YSYX_23060077_ALU_AND  6
`define YSYX_23060077_ALU_SLL  7
`define YSYX_23060077_ALU_SRL  8
`define YSYX_23060077_ALU_SRA  9
`define YSYX_23060077_ALU_PC   10
`endif

module ysyx_23060077_idu_queue #(
   parameter int DATA_WIDTH    = 32,
   parameter int DEPTH         = 4,
   parameter int ALU_OPT_WIDTH = 11
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_WIDTH-1:0]    in_pc,
   input  logic [DATA_WIDTH-1:0]    in_inst,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_WIDTH-1:0]    out_pc,
   output logic [4:0]               out_rd,
   output logic                     out_rd_wen,
   output logic [4:0]               out_rs1,
   output logic [4:0]               out_rs2,
   output logic [DATA_WIDTH-1:0]    out_imm,
   output logic [ALU_OPT_WIDTH-1:0] out_alu_opt,
   output logic [1:0]               out_src_sel,
   output logic [1:0]               out_lsu_opt,
   output logic [2:0]               out_funct3,
   output logic [10:0]              out_itype,
   output logic                     out_alu_mul,
   output logic                     out_alu_div,
   output logic                     out_illegal,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int BASE_W = 2*DATA_WIDTH + 16 + ALU_OPT_WIDTH + 19;
`ifdef YSYX_23060077_IDU_MEXT_EN
   localparam bit MEXT    = 1'b1;
   localparam int ENTRY_W = BASE_W + 2;
`else
   localparam bit MEXT    = 1'b0;
   localparam int ENTRY_W = BASE_W;
`endif
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [6:0]  w_opcode;
   logic [2:0]  w_funct3;
   logic [6:0]  w_funct7;
   logic        w_isLui, w_isAuipc, w_isJal, w_isJalr, w_isBranch, w_isLoad;
   logic        w_isStore, w_isOpImm, w_isOp, w_isFence, w_isSys;
   logic        w_isMext, w_opF7Ok, w_illegal, w_fmtI, w_fmtU;
   logic [10:0] w_itype;
   logic [31:0] w_imm32;
   logic [ALU_OPT_WIDTH-1:0] w_aluOpt;
   logic [4:0]  w_rd, w_rs1, w_rs2;
   logic        w_rdWen;
   logic [1:0]  w_srcSel, w_lsuOpt;
   logic [ENTRY_W-1:0] w_entryIn, w_head;
   logic        w_push, w_pop;

   logic [ENTRY_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]   r_wrPtr, r_rdPtr;
   logic [CNT_W-1:0]   r_count;

   assign w_opcode   = in_inst[6:0];
   assign w_funct3   = in_inst[14:12];
   assign w_funct7   = in_inst[31:25];
   assign w_isLui    = (w_opcode == 7'b0110111);
   assign w_isAuipc  = (w_opcode == 7'b0010111);
   assign w_isJal    = (w_opcode == 7'b1101111);
   assign w_isJalr   = (w_opcode == 7'b1100111);
   assign w_isBranch = (w_opcode == 7'b1100011);
   assign w_isLoad   = (w_opcode == 7'b0000011);
   assign w_isStore  = (w_opcode == 7'b0100011);
   assign w_isOpImm  = (w_opcode == 7'b0010011);
   assign w_isOp     = (w_opcode == 7'b0110011);
   assign w_isFence  = (w_opcode == 7'b0001111);
   assign w_isSys    = (w_opcode == 7'b1110011);
   assign w_itype    = {w_isSys, w_isFence, w_isOp, w_isOpImm, w_isStore, w_isLoad,
                        w_isBranch, w_isJalr, w_isJal, w_isAuipc, w_isLui};
   assign w_fmtI     = w_isJalr | w_isLoad | w_isOpImm;
   assign w_fmtU     = w_isLui | w_isAuipc;
   assign w_isMext   = w_isOp & (w_funct7 == 7'b0000001);
   assign w_opF7Ok   = (w_funct7 == 7'b0000000) | (w_funct7 == 7'b0100000) | (MEXT & w_isMext);

   // Opcode match already implies inst[1:0]=11; the explicit term keeps the rule readable.
   assign w_illegal  = (in_inst[1:0] != 2'b11) | ~(|w_itype)
                     | (w_isBranch & (w_funct3[2:1] == 2'b01))
                     | (w_isOp & ~w_opF7Ok);

   always_comb begin
      w_imm32 = 32'd0;
      if (w_fmtI)          w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      else if (w_fmtU)     w_imm32 = {in_inst[31:12], 12'b0};
      else if (w_isJal)    w_imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
      else if (w_isBranch) w_imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
      else if (w_isStore)  w_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      else if (w_isSys)    w_imm32 = {{15{in_inst[31]}}, in_inst[31:15]};
   end

   // Branch compares reuse SUB/SLT/SLTU; SLTI deliberately shares the SUB lane.
   always_comb begin
      w_aluOpt = '0;
      if (w_isLui) w_aluOpt[`YSYX_23060077_ALU_ADD] = 1'b1;
      if (w_isAuipc | w_isJal | w_isJalr) w_aluOpt[`YSYX_23060077_ALU_PC] = 1'b1;
      if (w_isBranch) begin
         case (w_funct3[2:1])
            2'b00:   w_aluOpt[`YSYX_23060077_ALU_SUB]  = 1'b1;
            2'b10:   w_aluOpt[`YSYX_23060077_ALU_SLT]  = 1'b1;
            2'b11:   w_aluOpt[`YSYX_23060077_ALU_SLTU] = 1'b1;
            default: w_aluOpt = '0;
         endcase
      end
      if (w_isOpImm | (w_isOp & ~w_isMext)) begin
         case (w_funct3)
            3'b000: begin
               if (w_isOp & in_inst[30]) w_aluOpt[`YSYX_23060077_ALU_SUB] = 1'b1;
               else                      w_aluOpt[`YSYX_23060077_ALU_ADD] = 1'b1;
            end
            3'b001:  w_aluOpt[`YSYX_23060077_ALU_SLL] = 1'b1;
            3'b010: begin
               if (w_isOpImm) w_aluOpt[`YSYX_23060077_ALU_SUB] = 1'b1;
               else           w_aluOpt[`YSYX_23060077_ALU_SLT] = 1'b1;
            end
            3'b011:  w_aluOpt[`YSYX_23060077_ALU_SLTU] = 1'b1;
            3'b100:  w_aluOpt[`YSYX_23060077_ALU_XOR]  = 1'b1;
            3'b101: begin
               if (in_inst[30]) w_aluOpt[`YSYX_23060077_ALU_SRA] = 1'b1;
               else             w_aluOpt[`YSYX_23060077_ALU_SRL] = 1'b1;
            end
            3'b110:  w_aluOpt[`YSYX_23060077_ALU_OR]  = 1'b1;
            default: w_aluOpt[`YSYX_23060077_ALU_AND] = 1'b1;
         endcase
      end
      if (w_illegal) w_aluOpt = '0;
   end

   assign w_rdWen  = (w_fmtU | w_isJal | w_fmtI | w_isSys | w_isOp) & ~w_illegal;
   assign w_rd     = w_rdWen ? in_inst[11:7] : 5'd0;
   assign w_rs1    = (w_fmtI | w_isSys | w_isBranch | w_isStore | w_isOp) ? in_inst[19:15] : 5'd0;
   assign w_rs2    = (w_isBranch | w_isStore | w_isOp) ? in_inst[24:20] : 5'd0;
   assign w_srcSel = {w_isAuipc | w_isBranch, w_isAuipc | w_isBranch | w_isOp};
   assign w_lsuOpt = {w_isStore, w_isLoad} & {2{~w_illegal}};

`ifdef YSYX_23060077_IDU_MEXT_EN
   logic w_aluMul, w_aluDiv;
   assign w_aluMul  = w_isMext & ~w_funct3[2];
   assign w_aluDiv  = w_isMext & w_funct3[2];
   assign w_entryIn = {in_pc, w_rd, w_rdWen, w_rs1, w_rs2, DATA_WIDTH'($signed(w_imm32)), w_aluOpt,
                       w_srcSel, w_lsuOpt, w_funct3, w_itype, w_illegal, w_aluMul, w_aluDiv};
   assign {out_pc, out_rd, out_rd_wen, out_rs1, out_rs2, out_imm, out_alu_opt, out_src_sel,
           out_lsu_opt, out_funct3, out_itype, out_illegal, out_alu_mul, out_alu_div} = w_head;
`else
   assign w_entryIn = {in_pc, w_rd, w_rdWen, w_rs1, w_rs2, DATA_WIDTH'($signed(w_imm32)), w_aluOpt,
                       w_srcSel, w_lsuOpt, w_funct3, w_itype, w_illegal};
   assign {out_pc, out_rd, out_rd_wen, out_rs1, out_rs2, out_imm, out_alu_opt, out_src_sel,
           out_lsu_opt, out_funct3, out_itype, out_illegal} = w_head;
   assign out_alu_mul = 1'b0;
   assign out_alu_div = 1'b0;
`endif

   assign w_head    = r_mem[r_rdPtr];
   assign in_ready  = (r_count != FULL_CNT);
   assign out_valid = (r_count != '0);
   assign count     = r_count;
   assign w_push    = in_valid & in_ready;
   assign w_pop     = out_valid & out_ready;

   // Flush wins over both handshakes; storage is left as-is since pointers alone define occupancy.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (flush) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wrPtr] <= w_entryIn;
            r_wrPtr        <= r_wrPtr + PTR_ONE;
         end
         if (w_pop) r_rdPtr <= r_rdPtr + PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_23060077_idu_queue.sv
// Directed testbench for ysyx_23060077_idu_queue: decode fields, FIFO ordering/backpressure, flush and async reset.

module tb_ysyx_23060077_idu_queue;

   localparam logic [10:0] ALU_ADD  = 11'h001;
   localparam logic [10:0] ALU_SUB  = 11'h002;
   localparam logic [10:0] IT_LUI   = 11'h001;
   localparam logic [10:0] IT_BR    = 11'h010;
   localparam logic [10:0] IT_STORE = 11'h040;
   localparam logic [10:0] IT_OPIMM = 11'h080;

   logic        clock = 1'b0;
   logic        reset_n, flush, inValid, outReady;
   logic [31:0] inPc, inInst;
   logic        inReady, outValid, outRdWen, outAluMul, outAluDiv, outIllegal;
   logic [31:0] outPc, outImm;
   logic [4:0]  outRd, outRs1, outRs2;
   logic [10:0] outAluOpt, outItype;
   logic [1:0]  outSrcSel, outLsuOpt;
   logic [2:0]  outFunct3;
   logic [2:0]  count;

   int totalChecks = 0;
   int badChecks   = 0;

   always #5 clock = ~clock;

   ysyx_23060077_idu_queue dut (
      .clock(clock), .reset_n(reset_n), .flush(flush),
      .in_valid(inValid), .in_ready(inReady), .in_pc(inPc), .in_inst(inInst),
      .out_valid(outValid), .out_ready(outReady), .out_pc(outPc),
      .out_rd(outRd), .out_rd_wen(outRdWen), .out_rs1(outRs1), .out_rs2(outRs2),
      .out_imm(outImm), .out_alu_opt(outAluOpt), .out_src_sel(outSrcSel),
      .out_lsu_opt(outLsuOpt), .out_funct3(outFunct3), .out_itype(outItype),
      .out_alu_mul(outAluMul), .out_alu_div(outAluDiv), .out_illegal(outIllegal),
      .count(count)
   );

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      totalChecks++;
      if (got !== exp) begin
         badChecks++;
         $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic [31:0] pc, input logic [31:0] inst,
                                input logic rdy);
      inValid  = valid;
      inPc     = pc;
      inInst   = inst;
      outReady = rdy;
   endtask

   task automatic stepCycle;
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset_n = 1'b0;
      flush   = 1'b0;
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
      #2;
      checkOutput("rst_valid", 64'(outValid), 64'd0);
      checkOutput("rst_ready", 64'(inReady), 64'd1);
      checkOutput("rst_count", 64'(count), 64'd0);
      checkOutput("rst_pc", 64'(outPc), 64'd0);
      checkOutput("rst_imm", 64'(outImm), 64'd0);
      checkOutput("rst_itype", 64'(outItype), 64'd0);
      #10 reset_n = 1'b1;
      stepCycle;

      // addi x1,x0,5
      applyStimulus(1'b1, 32'h8000_0000, 32'h00500093, 1'b1);
      checkOutput("addi_nobypass", 64'(outValid), 64'd0);
      stepCycle;
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
      checkOutput("addi_valid", 64'(outValid), 64'd1);
      checkOutput("addi_pc", 64'(outPc), 64'h8000_0000);
      checkOutput("addi_rd", 64'(outRd), 64'd1);
      checkOutput("addi_rdwen", 64'(outRdWen), 64'd1);
      checkOutput("addi_rs1", 64'(outRs1), 64'd0);
      checkOutput("addi_imm", 64'(outImm), 64'd5);
      checkOutput("addi_alu", 64'(outAluOpt), 64'(ALU_ADD));
      checkOutput("addi_itype", 64'(outItype), 64'(IT_OPIMM));
      checkOutput("addi_illegal", 64'(outIllegal), 64'd0);
      stepCycle;
      checkOutput("addi_drained", 64'(count), 64'd0);

      // lui x2 then beq x1,x2,8
      applyStimulus(1'b1, 32'h100, 32'h12345137, 1'b0);
      stepCycle;
      applyStimulus(1'b1, 32'h104, 32'h00208463, 1'b0);
      stepCycle;
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
      checkOutput("lui_count", 64'(count), 64'd2);
      checkOutput("lui_imm", 64'(outImm), 64'h1234_5000);
      checkOutput("lui_rd", 64'(outRd), 64'd2);
      checkOutput("lui_rs1", 64'(outRs1), 64'd0);
      checkOutput("lui_itype", 64'(outItype), 64'(IT_LUI));
      checkOutput("lui_alu", 64'(outAluOpt), 64'(ALU_ADD));
      outReady = 1'b1;
      stepCycle;
      checkOutput("beq_pc", 64'(outPc), 64'h104);
      checkOutput("beq_rs1", 64'(outRs1), 64'd1);
      checkOutput("beq_rs2", 64'(outRs2), 64'd2);
      checkOutput("beq_rd", 64'(outRd), 64'd0);
      checkOutput("beq_rdwen", 64'(outRdWen), 64'd0);
      checkOutput("beq_imm", 64'(outImm), 64'd8);
      checkOutput("beq_alu", 64'(outAluOpt), 64'(ALU_SUB));
      checkOutput("beq_srcsel", 64'(outSrcSel), 64'd3);
      checkOutput("beq_itype", 64'(outItype), 64'(IT_BR));
      stepCycle;
      checkOutput("beq_drained", 64'(outValid), 64'd0);

      // Fill to full (write pointer starts at 3, so this wraps), then drain with a 5th pending.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 32'h200 + 32'(4*i), {12'(10+i), 5'd0, 3'd0, 5'd1, 7'h13}, 1'b0);
         stepCycle;
      end
      checkOutput("full_count", 64'(count), 64'd4);
      checkOutput("full_ready", 64'(inReady), 64'd0);
      checkOutput("full_head", 64'(outImm), 64'd10);
      applyStimulus(1'b1, 32'h210, {12'd14, 5'd0, 3'd0, 5'd1, 7'h13}, 1'b0);
      stepCycle;
      checkOutput("full_hold_count", 64'(count), 64'd4);
      checkOutput("full_hold_head", 64'(outImm), 64'd10);
      outReady = 1'b1;
      stepCycle;
      checkOutput("full_pop_count", 64'(count), 64'd3);
      checkOutput("full_pop_head", 64'(outImm), 64'd11);
      checkOutput("full_pop_ready", 64'(inReady), 64'd1);
      stepCycle;
      checkOutput("both_count", 64'(count), 64'd3);
      checkOutput("both_head", 64'(outImm), 64'd12);
      inValid = 1'b0;
      stepCycle;
      checkOutput("drain_head13", 64'(outImm), 64'd13);
      stepCycle;
      checkOutput("drain_head14", 64'(outImm), 64'd14);
      checkOutput("drain_pc14", 64'(outPc), 64'h210);
      checkOutput("drain_count1", 64'(count), 64'd1);
      stepCycle;
      checkOutput("drain_empty", 64'(outValid), 64'd0);

      // Flush with both handshakes active.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 32'h300 + 32'(4*i), 32'h00500093, 1'b0);
         stepCycle;
      end
      checkOutput("flush_pre_count", 64'(count), 64'd3);
      flush = 1'b1;
      applyStimulus(1'b1, 32'h30C, 32'h00700093, 1'b1);
      stepCycle;
      checkOutput("flush_count", 64'(count), 64'd0);
      checkOutput("flush_valid", 64'(outValid), 64'd0);
      checkOutput("flush_ready", 64'(inReady), 64'd1);
      flush = 1'b0;
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
      stepCycle;
      checkOutput("flush_dropped", 64'(count), 64'd0);

      // mul, all-zero word, branch funct3=010, sw x2,-4(x1)
      applyStimulus(1'b1, 32'h400, 32'h022081B3, 1'b0);
      stepCycle;
      applyStimulus(1'b1, 32'h404, 32'h00000000, 1'b0);
      stepCycle;
      applyStimulus(1'b1, 32'h408, 32'h00002063, 1'b0);
      stepCycle;
      applyStimulus(1'b1, 32'h40C, 32'hFE20AE23, 1'b0);
      stepCycle;
      checkOutput("mul_pc", 64'(outPc), 64'h400);
`ifdef YSYX_23060077_IDU_MEXT_EN
      checkOutput("mul_illegal", 64'(outIllegal), 64'd0);
      checkOutput("mul_mul", 64'(outAluMul), 64'd1);
      checkOutput("mul_div", 64'(outAluDiv), 64'd0);
      checkOutput("mul_rdwen", 64'(outRdWen), 64'd1);
      checkOutput("mul_rd", 64'(outRd), 64'd3);
`else
      checkOutput("mul_illegal", 64'(outIllegal), 64'd1);
      checkOutput("mul_mul", 64'(outAluMul), 64'd0);
      checkOutput("mul_rdwen", 64'(outRdWen), 64'd0);
      checkOutput("mul_rd", 64'(outRd), 64'd0);
`endif
      checkOutput("mul_alu", 64'(outAluOpt), 64'd0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
      stepCycle;
      checkOutput("zero_illegal", 64'(outIllegal), 64'd1);
      checkOutput("zero_itype", 64'(outItype), 64'd0);
      checkOutput("zero_rdwen", 64'(outRdWen), 64'd0);
      stepCycle;
      checkOutput("badbr_illegal", 64'(outIllegal), 64'd1);
      checkOutput("badbr_itype", 64'(outItype), 64'(IT_BR));
      checkOutput("badbr_alu", 64'(outAluOpt), 64'd0);
      stepCycle;
      checkOutput("sw_illegal", 64'(outIllegal), 64'd0);
      checkOutput("sw_imm", 64'(outImm), 64'hFFFF_FFFC);
      checkOutput("sw_rs1", 64'(outRs1), 64'd1);
      checkOutput("sw_rs2", 64'(outRs2), 64'd2);
      checkOutput("sw_rd", 64'(outRd), 64'd0);
      checkOutput("sw_lsu", 64'(outLsuOpt), 64'd2);
      checkOutput("sw_itype", 64'(outItype), 64'(IT_STORE));
      checkOutput("sw_funct3", 64'(outFunct3), 64'd2);
      stepCycle;
      checkOutput("sw_drained", 64'(count), 64'd0);

      // Asynchronous reset mid-cycle with two entries queued.
      applyStimulus(1'b1, 32'h500, 32'h00500093, 1'b0);
      stepCycle;
      stepCycle;
      inValid = 1'b0;
      checkOutput("arst_pre_count", 64'(count), 64'd2);
      #3 reset_n = 1'b0;
      #1;
      checkOutput("arst_count", 64'(count), 64'd0);
      checkOutput("arst_valid", 64'(outValid), 64'd0);
      checkOutput("arst_pc", 64'(outPc), 64'd0);
      #1 reset_n = 1'b1;
      stepCycle;
      checkOutput("arst_ready", 64'(inReady), 64'd1);
      checkOutput("arst_post_count", 64'(count), 64'd0);

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule

// File: doc/ysyx_23060077_idu_queue.md
Name: ysyx_23060077_idu_queue

Overview:
- Registered decode stage for the RV32I(+M) core, sitting between the IFU and EXU.
- Accepts {pc, inst} over a valid/ready handshake and decodes fully at enqueue, including JAL/JALR/BRANCH/SYS, which are decoded internally rather than supplied from outside.
- Stores decoded bundles in a parametrised-depth FIFO and presents the head to the EXU over valid/ready.
- Adds an illegal-instruction flag, a pipeline flush, and optional M-extension decode.

Parameters:
- DATA_WIDTH, 32, instruction, immediate and PC width.
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- ALU_OPT_WIDTH, 11, width of the one-hot alu_opt; bit positions come from the YSYX_23060077_ALU_* defines.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous queue clear (redirect or trap).
- in_valid  in  1  IFU offers an instruction.
- in_ready  out  1  queue can accept.
- in_pc  in  DATA_WIDTH  instruction PC.
- in_inst  in  DATA_WIDTH  raw instruction.
- out_valid  out  1  head entry valid.
- out_ready  in  1  EXU accepts the head entry.
- out_pc  out  DATA_WIDTH  head PC.
- out_rd  out  5  destination register; 0 when rd_wen=0.
- out_rd_wen  out  1  register write enable.
- out_rs1  out  5  source register 1; 0 if unused.
- out_rs2  out  5  source register 2; 0 if unused.
- out_imm  out  DATA_WIDTH  decoded immediate.
- out_alu_opt  out  ALU_OPT_WIDTH  one-hot ALU operation.
- out_src_sel  out  2  operand select: {AUIPC|BRANCH, AUIPC|BRANCH|OP}.
- out_lsu_opt  out  2  {store, load}.
- out_funct3  out  3  inst[14:12].
- out_itype  out  11  one-hot type: {SYS,FENCE,OP,OP_IMM,STORE,LOAD,BRANCH,JALR,JAL,AUIPC,LUI}.
- out_alu_mul  out  1  multiply op.
- out_alu_div  out  1  divide/remainder op.
- out_illegal  out  1  undecodable instruction.
- count  out  log2(DEPTH)+1  occupancy.

Behaviour:
- Reset (reset_n=0, async):
  - Pointers and count go to 0, so out_valid=0 and in_ready=1.
  - All storage clears to 0, so every out_* field reads 0.
- Handshakes:
  - Enqueue fire = in_valid & in_ready. Dequeue fire = out_valid & out_ready.
  - in_ready = (count != DEPTH). There is no combinational path from out_ready to in_ready.
  - out_valid = (count != 0).
  - All out_* fields are driven combinationally from the head entry and are stable while out_valid=1 and out_ready=0.
- Latency: an instruction enqueued in cycle N appears at the head no earlier than N+1. There is no same-cycle bypass.
- Simultaneous enqueue and dequeue:
  - Allowed whenever not full; count is unchanged.
  - When full, only the dequeue occurs (in_ready=0).
- Pointers wrap modulo DEPTH.
- Flush:
  - On the next edge, count and both pointers go to 0.
  - Flush overrides an enqueue or dequeue in the same cycle: the instruction is dropped and the EXU handshake is ignored.
- Decode (combinational on in_inst, registered into the entry):
  - Opcodes:
    - LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011.
    - STORE 0100011, OP_IMM 0010011, OP 0110011, FENCE 0001111, SYS 1110011.
  - Immediates by format:
    - I (JALR/LOAD/OP_IMM): sign-extended inst[31:20].
    - U: {inst[31:12], 12'b0}.
    - J: sign-extended {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
    - B: sign-extended {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
    - S: sign-extended {inst[31:25], inst[11:7]}.
    - SYS: sign-extended inst[31:15], which carries csr and zimm.
  - Register usage:
    - rs1 is used for I, SYS, B, S and R formats.
    - rs2 is used for B, S and R formats.
    - rd_wen = U | J | I | SYS | R.
  - alu_opt:
    - ADD: LUI, ADDI, ADD.
    - SUB: BEQ, BNE, SLTI, SUB.
    - SLT: BLT, BGE, SLT.
    - SLTU: BLTU, BGEU, SLTIU, SLTU.
    - PC: AUIPC, JAL, JALR.
    - Remaining ops map to their own bit. inst[30] selects SRA/SUB.
  - out_illegal=1 when any of the following holds:
    - inst[1:0] != 11.
    - The opcode is not in the list above.
    - BRANCH with funct3 of 010 or 011.
    - OP with a funct7 other than 0000000, 0100000 or (if enabled) 0000001.
  - When out_illegal=1: rd_wen=0, alu_opt=0, lsu_opt=0.

Optional Feature:
- Macro: YSYX_23060077_IDU_MEXT_EN.
- Defined:
  - OP with funct7=0000001 sets alu_mul = ~funct3[2] and alu_div = funct3[2].
  - alu_opt=0 and rd_wen=1 for these instructions.
- Undefined:
  - alu_mul and alu_div are tied to 0 and carry no storage.
  - OP with funct7=0000001 is flagged illegal.

Test Plan:
- Reset, then enqueue 0x00500093 (addi x1,x0,5) with out_ready=1 -> next cycle out_valid=1, rd=1, rd_wen=1, rs1=0, imm=5, alu_opt=ADD, itype=OP_IMM.
- Enqueue 0x12345137 (lui x2), then 0x00208463 (beq x1,x2,8) -> lui: imm=0x12345000, rd=2. beq: rs1=1, rs2=2, rd=0, rd_wen=0, imm=8, alu_opt=SUB, src_sel=11.
- DEPTH=4, out_ready=0, push 5 instructions -> in_ready=0 after the 4th and count=4. Then raise out_ready with in_valid=1 -> 1 dequeue per cycle, and the 5th is accepted once count=3. Order is preserved across the pointer wrap.
- Queue holding 3 entries, flush asserted together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, in_ready=1, and the offered instruction is lost.
- Enqueue 0x022081B3 (mul x3,x1,x2) -> with the macro: alu_mul=1, alu_div=0, illegal=0. Without: illegal=1, rd_wen=0. Also enqueue 0x00000000 -> illegal=1 in both builds.
- Assert reset_n=0 mid-cycle with 2 entries queued -> count=0 and out_valid=0 immediately, without waiting for a clock edge.
